// File: rtl/prog_loader.sv
// Boot-time program loader: streams 32-bit words into instruction memory and holds the core in reset until an image commits.
// Optional macro LOADER_CHECKSUM_EN: the in_last beat carries a 32-bit wrap-around checksum instead of a program word.
module prog_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_overflow,
  output logic              err_checksum
);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RELEASE, RUN} state_e;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(MAX_WORDS - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              accept, start, load_beat, write_beat, last_ok;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic        cks_q, cks_d;

  assign write_beat = !in_last;
  assign last_ok    = (sum_q == in_data);
`else
  assign write_beat = 1'b1;
  assign last_ok    = 1'b1;
`endif

  // in_ready_q is only set in LOAD/DRAIN, so accept never fires elsewhere
  assign accept    = in_valid && in_ready_q;
  assign load_beat = accept && (state_q == LOAD);
  assign start     = load_req && ((state_q == IDLE) || (state_q == RUN));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
      cks_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      cks_q      <= cks_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load_req) state_d = LOAD;
      LOAD: begin
        if (accept) begin
          if (in_last)                  state_d = last_ok ? RELEASE : IDLE;
          else if (count_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN:   if (accept && in_last) state_d = IDLE;
      RELEASE: state_d = RUN;
      RUN:     if (load_req) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track the state register exactly
  always_comb begin
    in_ready_d = (state_d == LOAD) || (state_d == DRAIN);
    busy_d     = (state_d == LOAD) || (state_d == DRAIN);
    core_rst_d = (state_d != RUN);
    done_d     = (state_d == RUN);
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    if (start) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end
    if (load_beat && write_beat) begin
      we_d    = 1'b1;
      waddr_d = count_q[ADDR_W-1:0];
      wdata_d = in_data;
      count_d = count_q + CNT_ONE;
      if (!in_last && (count_q == LAST_IDX)) ovf_d = 1'b1;
    end
`ifdef LOADER_CHECKSUM_EN
    sum_d = sum_q;
    cks_d = cks_q;
    if (start) begin
      sum_d = '0;
      cks_d = 1'b0;
    end
    if (load_beat && write_beat)           sum_d = sum_q + in_data;
    if (load_beat && in_last && !last_ok)  cks_d = 1'b1;
`endif
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign core_rst     = core_rst_q;
  assign done         = done_q;
  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign word_count   = count_q;
  assign err_overflow = ovf_q;
`ifdef LOADER_CHECKSUM_EN
  assign err_checksum = cks_q;
`else
  assign err_checksum = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: a write scoreboard plus table-driven and hand-written load sequences.
// A second instance with MAX_WORDS=4 covers the overflow and exact-boundary cases.
module tb_prog_loader;
  localparam int AW = 8;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, load_req, load_req4, in_valid, in_last;
  logic [31:0]   in_data;
  logic          in_ready, imem_we, core_rst, busy, done, err_overflow, err_checksum;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;
  logic          in_ready4, imem_we4, core_rst4, busy4, done4, err_overflow4, err_checksum4;
  logic [AW-1:0] imem_waddr4;
  logic [31:0]   imem_wdata4;
  logic [AW:0]   word_count4;

  int checks = 0;
  int errors = 0;
  int idx = 0;
  int idx4 = 0;
  logic [AW+31:0] q[$];
  logic [AW+31:0] q4[$];
  logic [AW+31:0] e, e4;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(AW), .MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .core_rst(core_rst), .busy(busy), .done(done),
    .word_count(word_count), .err_overflow(err_overflow), .err_checksum(err_checksum)
  );

  prog_loader #(.ADDR_W(AW), .MAX_WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .load_req(load_req4), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_last(in_last), .imem_we(imem_we4), .imem_waddr(imem_waddr4),
    .imem_wdata(imem_wdata4), .core_rst(core_rst4), .busy(busy4), .done(done4),
    .word_count(word_count4), .err_overflow(err_overflow4), .err_checksum(err_checksum4)
  );

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Called at a falling edge: drive one cycle of stimulus, record expected writes, advance one cycle.
  task automatic step(input logic v, input logic [31:0] d, input logic l, input logic lr, input logic lr4);
    in_valid = v; in_data = d; in_last = l; load_req = lr; load_req4 = lr4;
    if (lr)  idx = 0;
    if (lr4) idx4 = 0;
    if (v && in_ready && !(CKS && l)) begin
      q.push_back({idx[AW-1:0], d});
      idx++;
    end
    if (v && in_ready4 && !(CKS && l)) begin
      if (idx4 < 4) q4.push_back({idx4[AW-1:0], d});
      idx4++;
    end
    @(negedge clk);
    in_valid = 1'b0; load_req = 1'b0; load_req4 = 1'b0;
  endtask

  // Every expected write must appear exactly one edge after its beat was accepted; nothing else may write.
  always @(posedge clk) begin
    #2;
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (!imem_we || ({imem_waddr, imem_wdata} !== e)) begin
        errors++;
        $display("FAIL wr: got we=%b addr=%0h data=%h, expected addr=%0h data=%h",
                 imem_we, imem_waddr, imem_wdata, e[AW+31:32], e[31:0]);
      end
    end else if (imem_we) begin
      checks++; errors++;
      $display("FAIL wr_unexpected: got addr=%0h data=%h, expected no write", imem_waddr, imem_wdata);
    end
    if (q4.size() != 0) begin
      e4 = q4.pop_front();
      checks++;
      if (!imem_we4 || ({imem_waddr4, imem_wdata4} !== e4)) begin
        errors++;
        $display("FAIL wr4: got we=%b addr=%0h data=%h, expected addr=%0h data=%h",
                 imem_we4, imem_waddr4, imem_wdata4, e4[AW+31:32], e4[31:0]);
      end
    end else if (imem_we4) begin
      checks++; errors++;
      $display("FAIL wr4_unexpected: got addr=%0h data=%h, expected no write", imem_waddr4, imem_wdata4);
    end
  end

`ifndef LOADER_CHECKSUM_EN
  typedef struct {
    logic          v;
    logic [31:0]   d;
    logic          l;
    logic          we;
    logic [AW-1:0] a;
    logic          crst;
    logic          dn;
  } vec_t;

  vec_t        tbl[13];
  logic [31:0] img[8];

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic l, input logic we,
                              input logic [AW-1:0] a, input logic crst, input logic dn);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.we = we; r.a = a; r.crst = crst; r.dn = dn;
    return r;
  endfunction
`endif

  initial begin
    rst = 1'b0; load_req = 1'b0; load_req4 = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 32'h0;
`ifndef LOADER_CHECKSUM_EN
    img = '{32'h02400313, 32'h00602223, 32'h00402383, 32'h00730463,
            32'h00001297, 32'h00001217, 32'h00A10113, 32'h00A20193};
    // Gapped load: idle rows carry junk with in_last=1 that must be ignored.
    tbl[0]  = mk(1'b1, img[0], 1'b0, 1'b1, 8'd0, 1'b1, 1'b0);
    tbl[1]  = mk(1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    tbl[2]  = mk(1'b1, img[1], 1'b0, 1'b1, 8'd1, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    tbl[5]  = mk(1'b1, img[2], 1'b0, 1'b1, 8'd2, 1'b1, 1'b0);
    tbl[6]  = mk(1'b1, img[3], 1'b0, 1'b1, 8'd3, 1'b1, 1'b0);
    tbl[7]  = mk(1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    tbl[9]  = mk(1'b1, img[4], 1'b0, 1'b1, 8'd4, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    tbl[11] = mk(1'b1, img[5], 1'b1, 1'b1, 8'd5, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
`endif

    #12;
    chkb("rst_core_rst", core_rst, 1'b1);
    chkb("rst_in_ready", in_ready, 1'b0);
    chkb("rst_we", imem_we, 1'b0);
    chk32("rst_waddr", 32'(imem_waddr), 32'h0);
    chk32("rst_wdata", imem_wdata, 32'h0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", done, 1'b0);
    chk32("rst_count", 32'(word_count), 32'h0);
    chkb("rst_ovf", err_overflow, 1'b0);
    chkb("rst_cks", err_checksum, 1'b0);
    chkb("rst_cks4", err_checksum4, 1'b0);
    rst = 1'b1;
    @(negedge clk);

`ifndef LOADER_CHECKSUM_EN
    // Back-to-back image
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chkb("load_in_ready", in_ready, 1'b1);
    chkb("load_busy", busy, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, img[i], (i == 5), 1'b0, 1'b0);
    chkb("rel_in_ready", in_ready, 1'b0);
    chkb("rel_core_rst", core_rst, 1'b1);
    chkb("rel_done", done, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chkb("run_core_rst", core_rst, 1'b0);
    chkb("run_done", done, 1'b1);
    chkb("run_busy", busy, 1'b0);
    chk32("t1_count", 32'(word_count), 32'd6);

    // Same image with gaps, restarted from RUN
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chkb("reload_core_rst", core_rst, 1'b1);
    chkb("reload_done", done, 1'b0);
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].l, 1'b0, 1'b0);
      chkb($sformatf("gap%0d_we", i), imem_we, tbl[i].we);
      if (tbl[i].we) begin
        chk32($sformatf("gap%0d_addr", i), 32'(imem_waddr), 32'(tbl[i].a));
        chk32($sformatf("gap%0d_data", i), imem_wdata, tbl[i].d);
      end
      chkb($sformatf("gap%0d_core_rst", i), core_rst, tbl[i].crst);
      chkb($sformatf("gap%0d_done", i), done, tbl[i].dn);
    end
    chk32("t2_count", 32'(word_count), 32'd6);

    // Overflow on the MAX_WORDS=4 instance
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chkb("ovf_ready4", in_ready4, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, img[i], (i == 5), 1'b0, 1'b0);
      if (i == 2) chkb("ovf_early4", err_overflow4, 1'b0);
      if (i == 3) begin
        chkb("ovf_flag4", err_overflow4, 1'b1);
        chk32("ovf_count4", 32'(word_count4), 32'd4);
        chkb("drain_ready4", in_ready4, 1'b1);
      end
    end
    chkb("ovf_idle_core_rst4", core_rst4, 1'b1);
    chkb("ovf_idle_ready4", in_ready4, 1'b0);
    chkb("ovf_idle_busy4", busy4, 1'b0);
    chkb("ovf_idle_done4", done4, 1'b0);
    chkb("ovf_sticky4", err_overflow4, 1'b1);
    chkb("main_still_run", done, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chkb("ovf_cleared4", err_overflow4, 1'b0);
    chk32("ovf_count_clr4", 32'(word_count4), 32'h0);

    // Last beat exactly at MAX_WORDS is legal
    for (int i = 0; i < 4; i++) step(1'b1, img[i], (i == 3), 1'b0, 1'b0);
    chkb("bound_ovf4", err_overflow4, 1'b0);
    chkb("bound_rel_core4", core_rst4, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chkb("bound_done4", done4, 1'b1);
    chkb("bound_core4", core_rst4, 1'b0);
    chk32("bound_count4", 32'(word_count4), 32'd4);

    // Async reset after 3 of 6 beats
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, img[i], 1'b0, 1'b0, 1'b0);
    #3 rst = 1'b0;
    #1;
    chkb("arst_core_rst", core_rst, 1'b1);
    chkb("arst_in_ready", in_ready, 1'b0);
    chkb("arst_we", imem_we, 1'b0);
    chkb("arst_busy", busy, 1'b0);
    chk32("arst_count", 32'(word_count), 32'h0);
    chkb("arst_done4", done4, 1'b0);
    chkb("arst_core4", core_rst4, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, img[i], (i == 5), 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chkb("fresh_done", done, 1'b1);
    chkb("fresh_core_rst", core_rst, 1'b0);
    chk32("fresh_count", 32'(word_count), 32'd6);

    // Reload two words from RUN
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chkb("t5_core_rst_hi", core_rst, 1'b1);
    chkb("t5_done_lo", done, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, img[6+i], (i == 1), 1'b0, 1'b0);
    chkb("t5_rel_core", core_rst, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chkb("t5_core_rst_lo", core_rst, 1'b0);
    chkb("t5_done", done, 1'b1);
    chk32("t5_count", 32'(word_count), 32'd2);
`else
    // Matching checksum
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h00000005, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000000A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000000F, 1'b1, 1'b0, 1'b0);
    chkb("cs_rel_core", core_rst, 1'b1);
    chkb("cs_rel_cks", err_checksum, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chkb("cs_done", done, 1'b1);
    chkb("cs_core_lo", core_rst, 1'b0);
    chk32("cs_count", 32'(word_count), 32'd2);

    // Mismatching checksum
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h00000005, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000000A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00000010, 1'b1, 1'b0, 1'b0);
    chkb("bad_cks", err_checksum, 1'b1);
    chkb("bad_core", core_rst, 1'b1);
    chkb("bad_ready", in_ready, 1'b0);
    chkb("bad_done", done, 1'b0);
    chk32("bad_count", 32'(word_count), 32'd2);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chkb("bad_core_hold", core_rst, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chkb("bad_cks_clr", err_checksum, 1'b0);
`endif

    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chkb("sb_drained", logic'((q.size() == 0) && (q4.size() == 0)), 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
